// File: rtl/can_pkg.sv
// Shared CAN definitions: FSM states, CRC-15 polynomial, field lengths and
// small helpers used by the encoder (and available to a decoder).
package can_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_CRC,
        ST_TAIL
    } can_state_e;

    localparam logic [14:0] CRC_POLY = 15'h4599;

    localparam int ID_A_LEN  = 11;
    localparam int ID_B_LEN  = 18;
    localparam int DLC_LEN   = 4;
    localparam int CRC_LEN   = 15;
    localparam int TAIL_LEN  = 13;
    localparam int STUFF_RUN = 5;

    // SOF + ID_A + RTR/IDE/r0 + DLC, and SOF + ID_A + SRR/IDE + ID_B + RTR/r1/r0 + DLC
    localparam int STD_HDR_LEN = 1 + ID_A_LEN + 3 + DLC_LEN;
    localparam int EXT_HDR_LEN = 1 + ID_A_LEN + 2 + ID_B_LEN + 3 + DLC_LEN;

    function automatic logic [3:0] data_bytes(input logic data_flag, input logic [3:0] dlc);
        if (!data_flag)
            return 4'd0;
        else if (dlc > 4'd8)
            return 4'd8;
        else
            return dlc;
    endfunction

    function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic data_bit);
        logic [14:0] shifted;
        shifted = {crc[13:0], 1'b0};
        return (data_bit ^ crc[14]) ? (shifted ^ CRC_POLY) : shifted;
    endfunction

endpackage

// File: rtl/can_stuffer.sv
// Bit-stuffing unit: tracks the run of identical transmitted bits and replaces
// the proposed bit with its complement after five in a row, stalling the caller.
module can_stuffer
    import can_pkg::*;
(
    input  logic Clock_TB,
    input  logic Reset_n,
    input  logic load,
    input  logic advance,
    input  logic stuff_en,
    input  logic data_bit,
    output logic tx_bit,
    output logic stall
);

    logic       last_bit_reg;
    logic [2:0] run_cnt_reg;

    assign stall  = stuff_en && (run_cnt_reg == 3'(STUFF_RUN));
    assign tx_bit = stall ? ~last_bit_reg : data_bit;

    always_ff @(posedge Clock_TB or negedge Reset_n) begin
        if (!Reset_n) begin
            last_bit_reg <= 1'b1;
            run_cnt_reg  <= '0;
        end else if (load) begin
            // SOF is dominant and opens the first run
            last_bit_reg <= 1'b0;
            run_cnt_reg  <= 3'd1;
        end else if (advance) begin
            if (!stuff_en) begin
                last_bit_reg <= data_bit;
                run_cnt_reg  <= '0;
            end else if (tx_bit != last_bit_reg) begin
                // a stuff bit always differs, so it also restarts the run here
                last_bit_reg <= tx_bit;
                run_cnt_reg  <= 3'd1;
            end else begin
                run_cnt_reg  <= run_cnt_reg + 3'd1;
            end
        end
    end

endmodule

// File: rtl/can_encoder.sv
// CAN 2.0 frame serializer: latches a frame request, emits header, data, CRC-15
// and recessive tail at CLKS_PER_BIT clocks per bit with bit stuffing.
module can_encoder
    import can_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic        Clock_TB,
    input  logic        Reset_n,
    input  logic        i_Start,
    input  logic        i_Estendido_Flag,
    input  logic        i_Data_Flag,
    input  logic [28:0] i_ID_Field,
    input  logic [3:0]  i_Data_Lenth,
    input  logic [63:0] i_Data_Field,
    output logic        o_Bit_Output,
    output logic        o_Busy,
    output logic        o_Done
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

    can_state_e  state_reg;
    logic [TW-1:0] timer_reg;
    logic [5:0]  ptr_reg;
    logic [14:0] crc_reg;
    logic        ext_flag_reg;
    logic        data_flag_reg;
    logic [28:0] id_reg;
    logic [3:0]  dlc_reg;
    logic [63:0] data_reg;
    logic        bit_out_reg;
    logic        busy_reg;
    logic        done_reg;

    logic [38:0] hdr_vec;
    logic [5:0]  hdr_idx;
    logic [5:0]  hdr_last;
    logic [3:0]  n_bytes;
    logic [5:0]  data_idx;
    logic [5:0]  data_last;
    logic [3:0]  crc_idx;
    logic        field_bit;
    logic        field_last;
    logic        stuff_en;
    logic        boundary;
    logic        start_accept;
    logic        tx_bit;
    logic        stall;

    // Header is left-aligned so bit 38 is always SOF regardless of format
    assign hdr_vec = ext_flag_reg ?
        {1'b0, id_reg[28:18], 1'b1, 1'b1, id_reg[17:0], ~data_flag_reg, 2'b00, dlc_reg} :
        {1'b0, id_reg[10:0], ~data_flag_reg, 2'b00, dlc_reg, 20'd0};
    assign hdr_idx   = 6'd38 - ptr_reg;
    assign hdr_last  = ext_flag_reg ? 6'(EXT_HDR_LEN - 1) : 6'(STD_HDR_LEN - 1);
    assign n_bytes   = data_bytes(data_flag_reg, dlc_reg);
    assign data_idx  = 6'd63 - ptr_reg;
    assign data_last = {3'(n_bytes - 4'd1), 3'b111};
    assign crc_idx   = 4'(6'(CRC_LEN - 1) - ptr_reg);

    assign boundary     = (state_reg != ST_IDLE) && (timer_reg == TIMER_LAST);
    assign start_accept = (state_reg == ST_IDLE) && i_Start;

    always_comb begin
        field_bit  = 1'b1;
        field_last = 1'b0;
        stuff_en   = 1'b0;
        case (state_reg)
            ST_HEADER: begin
                field_bit  = hdr_vec[hdr_idx];
                field_last = (ptr_reg == hdr_last);
                stuff_en   = 1'b1;
            end
            ST_DATA: begin
                field_bit  = data_reg[data_idx];
                field_last = (ptr_reg == data_last);
                stuff_en   = 1'b1;
            end
            ST_CRC: begin
                field_bit  = crc_reg[crc_idx];
                field_last = (ptr_reg == 6'(CRC_LEN - 1));
                stuff_en   = 1'b1;
            end
            ST_TAIL: begin
                // only a stuff bit owed by the last CRC bit may precede the delimiter
                stuff_en   = (ptr_reg == '0);
            end
            default: ;
        endcase
    end

    can_stuffer u_stuffer (
        .Clock_TB (Clock_TB),
        .Reset_n  (Reset_n),
        .load     (start_accept),
        .advance  (boundary),
        .stuff_en (stuff_en),
        .data_bit (field_bit),
        .tx_bit   (tx_bit),
        .stall    (stall)
    );

    always_ff @(posedge Clock_TB or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg     <= ST_IDLE;
            timer_reg     <= '0;
            ptr_reg       <= '0;
            crc_reg       <= '0;
            ext_flag_reg  <= 1'b0;
            data_flag_reg <= 1'b0;
            id_reg        <= '0;
            dlc_reg       <= '0;
            data_reg      <= '0;
            bit_out_reg   <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    timer_reg   <= '0;
                    bit_out_reg <= 1'b1;
                    if (i_Start) begin
                        ext_flag_reg  <= i_Estendido_Flag;
                        data_flag_reg <= i_Data_Flag;
                        id_reg        <= i_ID_Field;
                        dlc_reg       <= i_Data_Lenth;
                        data_reg      <= i_Data_Field;
                        state_reg     <= ST_HEADER;
                        ptr_reg       <= 6'd1;
                        // SOF is a 0 into a zero register, so the CRC stays 0
                        crc_reg       <= '0;
                        bit_out_reg   <= 1'b0;
                        busy_reg      <= 1'b1;
                    end
                end
                default: begin
                    timer_reg <= boundary ? '0 : timer_reg + 1'b1;
                    if (boundary) begin
                        if (state_reg == ST_TAIL && ptr_reg == 6'(TAIL_LEN)) begin
                            state_reg   <= ST_IDLE;
                            ptr_reg     <= '0;
                            crc_reg     <= '0;
                            bit_out_reg <= 1'b1;
                            busy_reg    <= 1'b0;
                            done_reg    <= 1'b1;
                        end else begin
                            bit_out_reg <= tx_bit;
                            if (!stall) begin
                                if (state_reg == ST_HEADER || state_reg == ST_DATA)
                                    crc_reg <= crc15_step(crc_reg, field_bit);
                                if (field_last) begin
                                    ptr_reg <= '0;
                                    case (state_reg)
                                        ST_HEADER: state_reg <= (n_bytes == 4'd0) ? ST_CRC : ST_DATA;
                                        ST_DATA:   state_reg <= ST_CRC;
                                        default:   state_reg <= ST_TAIL;
                                    endcase
                                end else begin
                                    ptr_reg <= ptr_reg + 6'd1;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign o_Bit_Output = bit_out_reg;
    assign o_Busy       = busy_reg;
    assign o_Done       = done_reg;

endmodule
